pc_ctrl: RTL
============

# pc_ctrl

Fetch-sequencing controller for the program-counter register. Each cycle it decides whether the PC holds, advances to PC+4, or loads a redirect target. Redirect sources are boot, branch, exception vector and exception return. It drives the PC register's write-enable, select and target-address inputs, handshakes with the instruction cache, and flushes the front-end pipeline on every redirect.

## Interface
Parameters:
- LENGTH, 32, address width; must match the PC register.
- BOOT_ADDR, 32'h0000_1000, first PC loaded after reset.
- EXC_VECTOR, 32'h0000_2000, exception handler entry address.
- DRAIN_CYCLES, 3, flush cycles between exception acceptance and vector load; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_cur  in  LENGTH  current PC, from the PC register output.
- stall_in  in  1  back-end stall; blocks sequential advance only.
- ic_ready  in  1  instruction cache has returned the word at pc_cur this cycle.
- br_valid  in  1  taken-branch redirect request, single-cycle pulse.
- br_target  in  LENGTH  branch destination.
- exc_valid  in  1  exception request, single-cycle pulse.
- exc_pc  in  LENGTH  PC of the faulting instruction.
- iret_valid  in  1  return-from-exception request.
- pc_wr  out  1  write enable to the PC register.
- pc_sel  out  1  0 = load PC+4, 1 = load pc_target.
- pc_target  out  LENGTH  redirect address.
- ic_req  out  1  fetch request to the instruction cache at pc_cur.
- flush  out  1  kill younger front-end instructions.
- epc  out  LENGTH  saved exception PC.
- busy  out  1  high in every state except FETCH.

## Operation
States: BOOT, FETCH, REDIR, DRAIN. Registers: state, 4-bit drain counter, epc.

- **BOOT:** ic_req=0. pc_wr=1, pc_sel=1, pc_target=BOOT_ADDR. Next state is REDIR.
- **FETCH:** ic_req=1. Requests are resolved in strict priority order exc > iret > branch > sequential.
  - exc_valid: epc<=exc_pc; flush=1; pc_wr=0; counter<=DRAIN_CYCLES-1; next state DRAIN.
  - iret_valid: pc_wr=1, pc_sel=1, pc_target=epc; flush=1; next state REDIR.
  - br_valid: pc_wr=1, pc_sel=1, pc_target={br_target[LENGTH-1:2],2'b00}; flush=1; next state REDIR.
  - else if ic_ready && !stall_in: pc_wr=1, pc_sel=0.
  - else: pc_wr=0 (hold).
  - Redirects are accepted regardless of stall_in or ic_ready. Any in-flight cache word is discarded by flush.
- **REDIR:** single bubble so the cache sees the new address. ic_req=0, pc_wr=0, flush=0. Next state is FETCH.
- **DRAIN:** flush=1, ic_req=0, pc_wr=0. br_valid, iret_valid and exc_valid are ignored; epc is not overwritten.
  - counter>0: decrement.
  - counter==0: pc_wr=1, pc_sel=1, pc_target=EXC_VECTOR; next state REDIR.
- When pc_wr=0, pc_sel=0 and pc_target=0.
- When not redirecting, the low two bits of pc_target are always 0.

## Timing
- All outputs are combinational from the registered state plus the current-cycle inputs. The PC register samples them on the same edge.
- Branch or iret: new PC is visible on pc_cur 1 cycle after the request. ic_req reasserts 2 cycles after the request.
- Exception: flush is asserted for DRAIN_CYCLES+1 cycles. pc_cur = EXC_VECTOR DRAIN_CYCLES+1 cycles after exc_valid.
- Reset: while reset is high, the next state is BOOT, the counter clears and epc<=0.
  - The first cycle after deassertion is BOOT, with outputs as listed under BOOT.
  - pc_cur = BOOT_ADDR one cycle later.
- Reset asserted during DRAIN or REDIR aborts the operation with no pending vector load.
- Sequential throughput: one PC+4 per cycle while ic_ready=1 and stall_in=0.

## Configuration
- **PC_CTRL_IRET_EN defined:** epc register, epc output and iret handling are present as described above.
- **PC_CTRL_IRET_EN undefined:**
  - iret_valid is ignored.
  - The epc register is removed and the epc output is tied to 0.
  - exc_pc is unused.
  - Exceptions still drain and vector.

## Test plan
- **Reset release:** reset high 2 cycles, then low → BOOT cycle with pc_wr=1, pc_target=32'h1000; next cycle pc_cur=32'h1000, busy=1; following cycle ic_req=1.
- **Sequential fetch:** ic_ready=1 for 4 cycles from 32'h1000 → pc_cur steps 1004, 1008, 100C, 1010. With stall_in=1 in cycle 2, PC holds at 1004 for that cycle.
- **Branch under stall:** stall_in=1, ic_ready=0, br_valid with br_target=32'h3007 → pc_wr=1, pc_target=32'h3004, flush=1; next cycle pc_cur=3004 and ic_req=0; the cycle after, ic_req=1.
- **Exception priority:** exc_valid, br_valid and iret_valid together, exc_pc=32'h1008 → epc=1008 and flush held 4 cycles (DRAIN_CYCLES=3); br_valid pulses during drain are ignored; pc_cur=32'h2000 afterwards.
- **Iret:** after the exception case, iret_valid → pc_cur=32'h1008 next cycle. With the macro undefined, iret_valid has no effect and epc reads 0.
- **Reset mid-drain:** reset asserted in the second DRAIN cycle → no load of EXC_VECTOR; BOOT follows and pc_cur=32'h1000.

Source files
------------

// File: rtl/pc_ctrl.sv
// PC fetch sequencer: hold / PC+4 / redirect (boot, branch, exception, iret); iret+epc under `PC_CTRL_IRET_EN.
// Latency: outputs are combinational from state and inputs; new PC appears one cycle after a redirect.
// Backpressure: stall_in or !ic_ready only holds sequential advance; redirects are always accepted.
module pc_ctrl #(
  parameter int                LENGTH       = 32,
  parameter logic [LENGTH-1:0] BOOT_ADDR    = LENGTH'(32'h0000_1000),
  parameter logic [LENGTH-1:0] EXC_VECTOR   = LENGTH'(32'h0000_2000),
  parameter int                DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LENGTH-1:0] pc_cur,
  input  logic              stall_in,
  input  logic              ic_ready,
  input  logic              br_valid,
  input  logic [LENGTH-1:0] br_target,
  input  logic              exc_valid,
  input  logic [LENGTH-1:0] exc_pc,
  input  logic              iret_valid,
  output logic              pc_wr,
  output logic              pc_sel,
  output logic [LENGTH-1:0] pc_target,
  output logic              ic_req,
  output logic              flush,
  output logic [LENGTH-1:0] epc,
  output logic              busy
);

  typedef enum logic [1:0] {BOOT, FETCH, REDIR, DRAIN} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

`ifdef PC_CTRL_IRET_EN
  logic [LENGTH-1:0] epc_q, epc_nxt;
  logic              unused_sigs;

  assign unused_sigs = ^pc_cur;
  assign epc         = epc_q;

  always_ff @(posedge clk) begin
    if (reset) epc_q <= '0;
    else       epc_q <= epc_nxt;
  end
`else
  logic unused_sigs;

  assign unused_sigs = ^{pc_cur, exc_pc, iret_valid};
  assign epc         = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign busy = (state != FETCH);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef PC_CTRL_IRET_EN
    epc_nxt   = epc_q;
`endif
    pc_wr     = 1'b0;
    pc_sel    = 1'b0;
    pc_target = '0;
    ic_req    = 1'b0;
    flush     = 1'b0;
    case (state)
      BOOT: begin
        pc_wr     = 1'b1;
        pc_sel    = 1'b1;
        pc_target = BOOT_ADDR;
        state_nxt = REDIR;
      end
      FETCH: begin
        ic_req = 1'b1;
        // Strict priority: exception, then iret, then branch, then sequential.
        if (exc_valid) begin
`ifdef PC_CTRL_IRET_EN
          epc_nxt   = exc_pc;
`endif
          flush     = 1'b1;
          cnt_nxt   = 4'(DRAIN_CYCLES - 1);
          state_nxt = DRAIN;
        end
`ifdef PC_CTRL_IRET_EN
        else if (iret_valid) begin
          pc_wr     = 1'b1;
          pc_sel    = 1'b1;
          pc_target = epc_q;
          flush     = 1'b1;
          state_nxt = REDIR;
        end
`endif
        else if (br_valid) begin
          pc_wr     = 1'b1;
          pc_sel    = 1'b1;
          pc_target = {br_target[LENGTH-1:2], 2'b00};
          flush     = 1'b1;
          state_nxt = REDIR;
        end else if (ic_ready && !stall_in) begin
          pc_wr = 1'b1;
        end
      end
      REDIR: begin
        state_nxt = FETCH;
      end
      DRAIN: begin
        flush = 1'b1;
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          pc_wr     = 1'b1;
          pc_sel    = 1'b1;
          pc_target = EXC_VECTOR;
          state_nxt = REDIR;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

endmodule
